// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial transmit path.
// Used by the scheduler and its arbiter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_END,
        GAP
    } tx_sched_state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int timeout, input int gap);
        return $clog2(((timeout > gap) ? timeout : gap) + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping past the top index.
module rr_arbiter
    import serial_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_idx
);

    int idx;

    // Walk from farthest to nearest so the nearest match wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one serial transmitter between requesters;
// loads a byte, tracks the busy flag, reports completion or start timeout.
module tx_scheduler
    import serial_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 32,
    parameter int GAP_CYCLES    = 2,
    localparam int ID_W = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx_load,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic                      timeout_err,
    output logic                      active
);

    localparam int CNT_W = cnt_w(START_TIMEOUT, GAP_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam tx_sched_state_t  EXIT_ST   = (GAP_CYCLES == 0) ? IDLE : GAP;

    tx_sched_state_t state, state_nxt;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  gap_cnt;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_idx;
    logic [DATA_W-1:0] sel_data;
    logic              take;
    logic              frame_end;
    logic              start_to;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req(req),
        .rr_ptr(rr_ptr),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx)
    );

    assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

    // The done/timeout cycle is never a grant cycle, so the next load
    // lands at least GAP_CYCLES+2 cycles after the pulse.
    assign take      = (state == IDLE) && grant_valid && !done && !timeout_err;
    assign frame_end = (state == WAIT_END) && !tx_busy;
    assign start_to  = (state == WAIT_START) && !tx_busy
                       && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (take) state_nxt = LOAD;
            LOAD:       state_nxt = WAIT_START;
            WAIT_START: begin
                if (tx_busy)       state_nxt = WAIT_END;
                else if (start_to) state_nxt = EXIT_ST;
            end
            WAIT_END:   if (frame_end) state_nxt = EXIT_ST;
            GAP:        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt     = '0;
        tx_load = (state == LOAD);
        active  = (state != IDLE);
        if (state == LOAD) gnt[cur_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            tx_data     <= '0;
            done        <= 1'b0;
            done_id     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            done        <= frame_end;
            timeout_err <= start_to;
            if (take) begin
                cur_id  <= grant_idx;
                tx_data <= sel_data;
            end
            if (state == LOAD) begin
                rr_ptr   <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
                wait_cnt <= '0;
            end
            if (state == WAIT_START && !tx_busy && wait_cnt != WAIT_LAST)
                wait_cnt <= wait_cnt + 1'b1;
            if (frame_end || start_to) begin
                done_id <= cur_id;
                gap_cnt <= '0;
            end
            if (state == GAP && gap_cnt != GAP_LAST)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler with a small behavioural transmitter
// (start bit, 8 data bits LSB first, stop bit).
module tb_tx_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        done;
    logic [1:0]  done_id;
    logic        timeout_err;
    logic        active;

    tx_scheduler dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .tx_load(tx_load),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .done(done),
        .done_id(done_id),
        .timeout_err(timeout_err),
        .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model; tx_off keeps it deaf to loads.
    logic       tx_off;
    logic       m_busy;
    logic [9:0] m_sh;
    logic [9:0] m_rx;
    int         m_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_sh   <= '1;
            m_rx   <= '0;
            m_n    <= 0;
        end else if (tx_load && !tx_off) begin
            m_busy <= 1'b1;
            m_sh   <= {1'b1, tx_data, 1'b0};
            m_rx   <= '0;
            m_n    <= 0;
        end else if (m_busy) begin
            m_rx <= {m_sh[0], m_rx[9:1]};
            m_sh <= {1'b1, m_sh[9:1]};
            m_n  <= m_n + 1;
            if (m_n == 9) m_busy <= 1'b0;
        end
    end

    assign tx_busy = m_busy;

    int n_pass;
    int n_total;
    int cyc;
    logic drop_on_gnt;
    logic [3:0] gnt_seen;
    logic [1:0] to_id;
    int         load_cyc[$];
    logic [3:0] gnt_log[$];
    logic [7:0] data_log[$];
    int         done_cyc[$];
    logic [1:0] id_log[$];
    int         to_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_load) begin
            load_cyc.push_back(cyc);
            gnt_log.push_back(gnt);
            data_log.push_back(tx_data);
        end
        if (done) begin
            done_cyc.push_back(cyc);
            id_log.push_back(done_id);
        end
        if (timeout_err) begin
            to_cyc.push_back(cyc);
            to_id = done_id;
        end
        gnt_seen = gnt_seen | gnt;
        if (drop_on_gnt) req = req & ~gnt;
    endtask

    task automatic clear_logs();
        load_cyc.delete();
        gnt_log.delete();
        data_log.delete();
        done_cyc.delete();
        id_log.delete();
        to_cyc.delete();
        gnt_seen = '0;
        to_id    = '0;
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_load"}, 32'(tx_load), 32'd0);
        chk({tag, "_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_id"}, 32'(done_id), 32'd0);
        chk({tag, "_to"}, 32'(timeout_err), 32'd0);
        chk({tag, "_active"}, 32'(active), 32'd0);
    endtask

    int c0;
    int t0;
    logic [9:0] frame;

    initial begin
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        reset = 1'b1;
        req = '0;
        req_data = '0;
        tx_off = 1'b0;
        drop_on_gnt = 1'b1;
        clear_logs();
        @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b0;

        // Single request from requester 0.
        req_data[7:0] = 8'hA5;
        c0 = cyc;
        req = 4'b0001;
        for (int i = 0; i < 100 && done_cyc.size() < 1; i++) tick();
        frame = {1'b1, 8'hA5, 1'b0};
        chk("s_ndone", 32'(done_cyc.size()), 32'd1);
        chk("s_nload", 32'(load_cyc.size()), 32'd1);
        chk("s_lat", 32'(load_cyc[0] - c0), 32'd1);
        chk("s_gnt", 32'(gnt_log[0]), 32'h1);
        chk("s_data", 32'(data_log[0]), 32'hA5);
        chk("s_hold", 32'(tx_data), 32'hA5);
        chk("s_pin", 32'(m_rx), 32'(frame));
        chk("s_dlat", 32'(done_cyc[0] - load_cyc[0]), 32'd12);
        chk("s_id", 32'(id_log[0]), 32'd0);
        chk("s_noto", 32'(to_cyc.size()), 32'd0);
        repeat (4) tick();
        chk("s_idle", 32'(active), 32'd0);

        // All four at once, each dropping on its grant.
        do_reset();
        req_data = 32'h4433_2211;
        req = 4'b1111;
        for (int i = 0; i < 400 && done_cyc.size() < 4; i++) tick();
        chk("a_ndone", 32'(done_cyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_gnt%0d", i), 32'(gnt_log[i]), 32'(1 << i));
            chk($sformatf("a_data%0d", i), 32'(data_log[i]),
                32'(8'h11 * (i + 1)));
            chk($sformatf("a_id%0d", i), 32'(id_log[i]), 32'(i));
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("a_gap%0d", i),
                32'(load_cyc[i+1] - done_cyc[i] >= 4), 32'd1);

        // Two requesters held high alternate.
        do_reset();
        drop_on_gnt = 1'b0;
        req_data = 32'h0000_BBAA;
        req = 4'b0011;
        for (int i = 0; i < 300 && load_cyc.size() < 6; i++) tick();
        req = 4'b0000;
        drop_on_gnt = 1'b1;
        chk("f_nload", 32'(load_cyc.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("f_gnt%0d", i), 32'(gnt_log[i]),
                (i % 2 == 0) ? 32'h1 : 32'h2);
        for (int i = 0; i < 100 && active; i++) tick();
        chk("f_idle", 32'(active), 32'd0);

        // Transmitter never starts.
        do_reset();
        tx_off = 1'b1;
        req_data = 32'h0077_0000;
        req = 4'b0100;
        for (int i = 0; i < 200 && to_cyc.size() < 1; i++) tick();
        chk("t_nto", 32'(to_cyc.size()), 32'd1);
        chk("t_gnt", 32'(gnt_log[0]), 32'h4);
        chk("t_lat", 32'(to_cyc[0] - load_cyc[0]), 32'd33);
        chk("t_id", 32'(to_id), 32'd2);
        chk("t_nodone", 32'(done_cyc.size()), 32'd0);
        repeat (2) tick();
        chk("t_gap", 32'(active), 32'd1);
        tick();
        chk("t_idle", 32'(active), 32'd0);
        chk("t_nodone2", 32'(done_cyc.size()), 32'd0);
        tx_off = 1'b0;

        // Reset while the frame is on the wire.
        do_reset();
        req_data = 32'h0000_005A;
        req = 4'b0001;
        for (int i = 0; i < 50 && !tx_busy; i++) tick();
        repeat (3) tick();
        chk("r_mid", 32'(active), 32'd1);
        req_data[31:24] = 8'hC3;
        req = 4'b1000;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("r_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < 100 && done_cyc.size() < 1; i++) tick();
        chk("r_nload", 32'(load_cyc.size()), 32'd1);
        chk("r_gnt", 32'(gnt_log[0]), 32'h8);
        chk("r_data", 32'(data_log[0]), 32'hC3);
        chk("r_id", 32'(id_log[0]), 32'd3);

        // Short-lived request during a frame is never served.
        do_reset();
        req_data = 32'h0000_993C;
        req = 4'b0001;
        for (int i = 0; i < 50 && !tx_busy; i++) tick();
        repeat (3) tick();
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        for (int i = 0; i < 100 && done_cyc.size() < 1; i++) tick();
        repeat (10) tick();
        chk("w_nload", 32'(load_cyc.size()), 32'd1);
        chk("w_gnts", 32'(gnt_seen), 32'h1);
        chk("w_id", 32'(id_log[0]), 32'd0);
        chk("w_idle", 32'(active), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
